// File: rtl/aclk_time_counter.sv
// 24-hour BCD hours/minutes counter for the alarm clock: counts one_second ticks,
// advances HH:MM, and accepts a validated keyed-in time with a sticky error flag.
module aclk_time_counter #(
    parameter int MINUTE_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       one_minute,
    output logic       load_error
);

    localparam int SEC_W = $clog2(MINUTE_TICKS) + 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(MINUTE_TICKS - 1);
    localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

    // Time is kept packed as {ms_hr, ls_hr, ms_min, ls_min}.
    logic [15:0]      time_q, time_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic             one_minute_q, one_minute_d;
    logic             load_error_q, load_error_d;
    logic [15:0]      new_time;

    function automatic logic time_is_valid(input logic [15:0] t);
        logic [3:0] mh, lh, mm, lm;
        {mh, lh, mm, lm} = t;
        return (mh <= 4'd2) && (lh <= 4'd9) && !((mh == 4'd2) && (lh > 4'd3))
            && (mm <= 4'd5) && (lm <= 4'd9);
    endfunction

    function automatic logic [15:0] advance_minute(input logic [15:0] t);
        logic [3:0] mh, lh, mm, lm;
        {mh, lh, mm, lm} = t;
        if (lm < 4'd9) begin
            lm = lm + 4'd1;
        end else if (mm < 4'd5) begin
            lm = 4'd0;
            mm = mm + 4'd1;
        end else begin
            lm = 4'd0;
            mm = 4'd0;
            if ((mh == 4'd2) && (lh == 4'd3)) begin
                mh = 4'd0;
                lh = 4'd0;
            end else if (lh == 4'd9) begin
                lh = 4'd0;
                mh = mh + 4'd1;
            end else begin
                lh = lh + 4'd1;
            end
        end
        return {mh, lh, mm, lm};
    endfunction

    assign new_time = {new_current_time_ms_hr, new_current_time_ls_hr,
                       new_current_time_ms_min, new_current_time_ls_min};

    // A load request, valid or not, swallows any tick arriving in the same cycle.
    always_comb begin
        time_d       = time_q;
        sec_cnt_d    = sec_cnt_q;
        load_error_d = load_error_q;
        one_minute_d = 1'b0;
        if (load_new_c) begin
            if (time_is_valid(new_time)) begin
                time_d       = new_time;
                sec_cnt_d    = '0;
                load_error_d = 1'b0;
            end else begin
                load_error_d = 1'b1;
            end
        end else if (one_second) begin
            if (sec_cnt_q == SEC_LAST) begin
                sec_cnt_d    = '0;
                time_d       = advance_minute(time_q);
                one_minute_d = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + SEC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q       <= '0;
            sec_cnt_q    <= '0;
            one_minute_q <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            time_q       <= time_d;
            sec_cnt_q    <= sec_cnt_d;
            one_minute_q <= one_minute_d;
            load_error_q <= load_error_d;
        end
    end

    assign {current_time_ms_hr, current_time_ls_hr,
            current_time_ms_min, current_time_ls_min} = time_q;
    assign one_minute = one_minute_q;
    assign load_error = load_error_q;

endmodule
